// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the buffered UART transmitter.
//   bit_cycles() : clocks per serial bit, rounded to nearest
//   tx_state_t   : transmitter FSM state encoding
//   FRAME_BITS   : bits per 8N1 frame (start + 8 data + stop)
//   DATA_BITS    : data bits per frame
package uart_pkg;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Rounded division so e.g. 50 MHz / 9600 gives 5208 rather than truncating.
    function automatic int bit_cycles(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// uart_tx_buffered_if -- write-side bus of the buffered UART transmitter.
//   wr_en, wr_data : byte write strobe and data (driven by master)
//   fifo_full      : FIFO holds DEPTH bytes
//   fifo_empty     : FIFO holds no bytes
//   level          : FIFO occupancy, $clog2(DEPTH)+1 bits
//   overflow       : sticky, a write was dropped because the FIFO was full
interface uart_tx_buffered_if #(
    parameter int DEPTH = 16
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             wr_en;
    logic [7:0]       wr_data;
    logic             fifo_full;
    logic             fifo_empty;
    logic [LVL_W-1:0] level;
    logic             overflow;

    modport master (
        output wr_en, wr_data,
        input  fifo_full, fifo_empty, level, overflow
    );

    modport slave (
        input  wr_en, wr_data,
        output fifo_full, fifo_empty, level, overflow
    );

endinterface

// File: rtl/tx_sync_fifo.sv
// tx_sync_fifo -- single-clock DEPTH x 8 FIFO with show-ahead read.
//   clk, reset_n : clock, asynchronous active-high reset
//   wr_en/wr_data: write; ignored while full
//   rd_en        : pop the head entry; ignored while empty
//   rd_data      : head entry, valid whenever empty is low
//   full, empty, level : status derived from the registered pointers
module tx_sync_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    // Extra pointer MSB distinguishes full from empty when the addresses match.
    assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign level = wr_ptr - rd_ptr;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_ok) rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers alone
    // define which entries are valid, and leaving it unreset keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[ADDR_W-1:0]];

endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered -- 8N1 UART transmitter fed from a DEPTH-entry byte FIFO.
//   clk_50MHz : system clock, rising edge
//   reset_n   : asynchronous, active-high reset (aborts any frame, flushes FIFO)
//   bus       : write side (wr_en, wr_data, fifo_full, fifo_empty, level, overflow)
//   tx        : registered serial line, idle high
//   busy      : a frame is in progress (state != IDLE)
// Frames are sent back to back while the FIFO has data. tx is registered from
// the state, so the line trails the FSM by one clock; bit widths are unaffected.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 9600,
    parameter int DEPTH  = 16
) (
    input  logic              clk_50MHz,
    input  logic              reset_n,
    uart_tx_buffered_if.slave bus,
    output logic              tx,
    output logic              busy
);

    localparam int BIT_CYCLES = bit_cycles(CLK_HZ, BAUD);
    localparam int CNT_W      = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int BIT_IDX_W  = $clog2(DATA_BITS);
    localparam int LVL_W      = $clog2(DEPTH) + 1;

    localparam logic [CNT_W-1:0]     BAUD_LAST = CNT_W'(BIT_CYCLES - 1);
    localparam logic [BIT_IDX_W-1:0] BIT_LAST  = BIT_IDX_W'(DATA_BITS - 1);

    tx_state_t            state;
    logic [CNT_W-1:0]     baud_cnt;
    logic [BIT_IDX_W-1:0] bit_cnt;
    logic [7:0]           shift;
    logic                 tx_q;
    logic                 overflow_q;

    logic                 baud_end;
    logic                 pop;
    logic [7:0]           fifo_rd_data;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [LVL_W-1:0]     fifo_level;

    tx_sync_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk     (clk_50MHz),
        .reset_n (reset_n),
        .wr_en   (bus.wr_en),
        .wr_data (bus.wr_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign baud_end = (baud_cnt == BAUD_LAST);

    // Pop from IDLE, or at the very end of a stop bit so the next start bit
    // follows with no idle gap.
    assign pop = !fifo_empty && ((state == IDLE) || (state == STOP && baud_end));

    always_ff @(posedge clk_50MHz or posedge reset_n) begin
        if (reset_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            tx_q     <= 1'b1;
        end else begin
            unique case (state)
                IDLE:  tx_q <= 1'b1;
                START: tx_q <= 1'b0;
                DATA:  tx_q <= shift[0];
                STOP:  tx_q <= 1'b1;
                default: tx_q <= 1'b1;
            endcase

            unique case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    if (pop) begin
                        shift <= fifo_rd_data;
                        state <= START;
                    end
                end
                START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        shift    <= {1'b0, shift[7:1]};
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            state   <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_IDX_W'(1);
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shift <= fifo_rd_data;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky until reset: any write presented while full is lost.
    always_ff @(posedge clk_50MHz or posedge reset_n) begin
        if (reset_n) begin
            overflow_q <= 1'b0;
        end else if (bus.wr_en && fifo_full) begin
            overflow_q <= 1'b1;
        end
    end

    assign tx             = tx_q;
    assign busy           = (state != IDLE);
    assign bus.fifo_full  = fifo_full;
    assign bus.fifo_empty = fifo_empty;
    assign bus.level      = fifo_level;
    assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered -- self-checking bench for uart_tx_buffered.
// Runs with a short bit time (round(1000/60) = 17 clocks) so many frames fit.
// A line monitor decodes frames from tx independently of the design.
module tb_uart_tx_buffered;

    localparam int CLK_HZ = 1000;
    localparam int BAUD   = 60;
    localparam int DEPTH  = 16;
    localparam int BIT    = 17;          // round(1000/60) = round(16.67)
    localparam int FRAME  = 10 * BIT;

    logic clk_50MHz = 1'b0;
    logic reset_n   = 1'b0;
    logic tx;
    logic busy;

    uart_tx_buffered_if #(.DEPTH(DEPTH)) bus ();

    uart_tx_buffered #(
        .CLK_HZ(CLK_HZ),
        .BAUD  (BAUD),
        .DEPTH (DEPTH)
    ) dut (
        .clk_50MHz(clk_50MHz),
        .reset_n  (reset_n),
        .bus      (bus.slave),
        .tx       (tx),
        .busy     (busy)
    );

    always #5 clk_50MHz = ~clk_50MHz;

    int cyc = 0;
    always @(posedge clk_50MHz) cyc++;

    int tests    = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- line monitor ----------------
    typedef struct {
        logic [9:0] bits;      // bits[0] = first bit on the line (start)
        int         fall_cyc;  // cycle count at the first low sample
        bit         stable;    // no change inside any bit period
    } frame_t;

    frame_t rx_q[$];
    frame_t mon_f;
    bit     mon_active = 1'b0;
    logic   mon_prev   = 1'b1;
    int     mon_n      = 0;

    always @(negedge clk_50MHz) begin
        if (reset_n) begin
            mon_active = 1'b0;
            mon_prev   = 1'b1;
        end else begin
            if (!mon_active && mon_prev === 1'b1 && tx === 1'b0) begin
                mon_active      = 1'b1;
                mon_n           = 0;
                mon_f.bits      = '0;
                mon_f.fall_cyc  = cyc;
                mon_f.stable    = 1'b1;
            end
            if (mon_active) begin
                if (mon_n % BIT == 0) mon_f.bits[mon_n / BIT] = tx;
                else if (tx !== mon_f.bits[mon_n / BIT]) mon_f.stable = 1'b0;
                mon_n++;
                if (mon_n == FRAME) begin
                    rx_q.push_back(mon_f);
                    mon_active = 1'b0;
                end
            end
            mon_prev = tx;
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk_50MHz);
    endtask

    task automatic get_frame(output frame_t f);
        int n = 0;
        while (rx_q.size() == 0 && n < 4 * FRAME) begin
            @(negedge clk_50MHz);
            n++;
        end
        check("frame_arrived", rx_q.size() > 0, 1);
        if (rx_q.size() > 0) f = rx_q.pop_front();
        else begin
            f.bits = '0; f.fall_cyc = 0; f.stable = 1'b0;
        end
    endtask

    task automatic check_frame(input string tag, input frame_t f, input logic [7:0] exp);
        check({tag, "_start"},  f.bits[0], 1'b0);
        check({tag, "_stop"},   f.bits[9], 1'b1);
        check({tag, "_stable"}, f.stable, 1'b1);
        check({tag, "_data"},   f.bits[8:1], exp);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || !bus.fifo_empty) && n < 20 * FRAME) begin
            @(negedge clk_50MHz);
            n++;
        end
        check("idle_reached", busy || !bus.fifo_empty, 0);
    endtask

    // ---------------- stimulus ----------------
    typedef struct {
        logic [7:0] data;
        logic [9:0] line;   // expected line bits, index 0 sent first
    } vec_t;

    vec_t vecs[6];
    logic [7:0] exp_q[$];

    initial begin
        frame_t f, f1, f2;
        int acc, first_busy, last_busy;

        vecs[0] = '{8'h31, 10'b1001100010};
        vecs[1] = '{8'h00, 10'b1000000000};
        vecs[2] = '{8'hFF, 10'b1111111110};
        vecs[3] = '{8'h55, 10'b1010101010};
        vecs[4] = '{8'hA5, 10'b1101001010};
        vecs[5] = '{8'h80, 10'b1100000000};

        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        #1 reset_n = 1'b1;
        repeat (3) @(negedge clk_50MHz);

        // Reset state
        check("rst_tx",       tx, 1'b1);
        check("rst_busy",     busy, 1'b0);
        check("rst_overflow", bus.overflow, 1'b0);
        check("rst_level",    bus.level, 0);
        check("rst_empty",    bus.fifo_empty, 1'b1);
        check("rst_full",     bus.fifo_full, 1'b0);
        reset_n = 1'b0;
        @(negedge clk_50MHz);
        check("idle_tx", tx, 1'b1);

        // Table: single bytes into an idle, empty FIFO
        foreach (vecs[i]) begin
            bus.wr_en   = 1'b1;
            bus.wr_data = vecs[i].data;
            @(negedge clk_50MHz);
            bus.wr_en = 1'b0;
            acc = cyc;
            first_busy = -1;
            last_busy  = -1;
            for (int k = 0; k < FRAME + 5; k++) begin
                @(negedge clk_50MHz);
                if (busy && first_busy < 0) first_busy = cyc;
                if (busy) last_busy = cyc;
            end
            get_frame(f);
            check($sformatf("vec%0d_line", i), f.bits, vecs[i].line);
            check($sformatf("vec%0d_stable", i), f.stable, 1'b1);
            check($sformatf("vec%0d_latency", i), f.fall_cyc - acc, 2);
            check($sformatf("vec%0d_busy_rise", i), first_busy - acc, 1);
            check($sformatf("vec%0d_busy_fall", i), last_busy - acc, FRAME);
        end

        // Three bytes on consecutive cycles: back-to-back frames
        wait_idle();
        bus.wr_en = 1'b1;
        bus.wr_data = 8'h31;
        @(negedge clk_50MHz);
        acc = cyc;
        bus.wr_data = 8'h32;
        @(negedge clk_50MHz);
        bus.wr_data = 8'h33;
        @(negedge clk_50MHz);
        bus.wr_en = 1'b0;
        wait_cyc(acc + 2 * FRAME);
        check("b2b_level_before_3rd_pop", bus.level, 1);
        @(negedge clk_50MHz);
        check("b2b_level_after_3rd_pop", bus.level, 0);
        check("b2b_empty_after_3rd_pop", bus.fifo_empty, 1'b1);
        get_frame(f);
        get_frame(f1);
        get_frame(f2);
        check_frame("b2b0", f, 8'h31);
        check_frame("b2b1", f1, 8'h32);
        check_frame("b2b2", f2, 8'h33);
        check("b2b_latency", f.fall_cyc - acc, 2);
        check("b2b_gap01", f1.fall_cyc - f.fall_cyc, FRAME);
        check("b2b_gap12", f2.fall_cyc - f1.fall_cyc, FRAME);

        // 17 writes while idle fill the FIFO exactly; 18th is dropped
        wait_idle();
        exp_q.delete();
        acc = cyc + 1;
        bus.wr_en = 1'b1;
        for (int k = 0; k < 17; k++) begin
            bus.wr_data = 8'($urandom);
            exp_q.push_back(bus.wr_data);
            @(negedge clk_50MHz);
        end
        check("fill_level", bus.level, 16);
        check("fill_full", bus.fifo_full, 1'b1);
        check("fill_overflow", bus.overflow, 1'b0);
        bus.wr_data = 8'hEE;
        @(negedge clk_50MHz);
        bus.wr_en = 1'b0;
        check("drop_overflow", bus.overflow, 1'b1);
        check("drop_level", bus.level, 16);

        // Write coincident with a pop: rejected at level 16, accepted at 15
        wait_cyc(acc + FRAME);
        bus.wr_en = 1'b1;
        bus.wr_data = 8'hDD;
        @(negedge clk_50MHz);
        bus.wr_en = 1'b0;
        check("pop_full_write_level", bus.level, 15);
        wait_cyc(acc + 2 * FRAME);
        check("pre_pop_level", bus.level, 15);
        bus.wr_en = 1'b1;
        bus.wr_data = 8'h77;
        exp_q.push_back(8'h77);
        @(negedge clk_50MHz);
        bus.wr_en = 1'b0;
        check("pop_write_level", bus.level, 15);
        for (int k = 0; k < 18; k++) begin
            get_frame(f);
            check_frame($sformatf("fill%0d", k), f, exp_q[k]);
        end
        wait_idle();
        check("fill_overflow_sticky", bus.overflow, 1'b1);

        // Reset in the middle of a data bit with bytes still queued
        bus.wr_en = 1'b1;
        bus.wr_data = 8'h55;
        @(negedge clk_50MHz);
        acc = cyc;
        for (int k = 0; k < 3; k++) begin
            bus.wr_data = 8'h10 + 8'(k);
            @(negedge clk_50MHz);
        end
        bus.wr_en = 1'b0;
        check("mid_level_queued", bus.level, 3);
        wait_cyc(acc + 2 + 4 * BIT + BIT / 2);
        check("mid_tx_bit3", tx, 1'b0);
        #2 reset_n = 1'b1;
        #1;
        check("mid_rst_tx", tx, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_level", bus.level, 0);
        check("mid_rst_empty", bus.fifo_empty, 1'b1);
        check("mid_rst_overflow", bus.overflow, 1'b0);
        repeat (3) @(negedge clk_50MHz);
        check("mid_no_partial_frame", rx_q.size(), 0);
        reset_n = 1'b0;
        bus.wr_en = 1'b1;
        bus.wr_data = 8'hA5;
        @(negedge clk_50MHz);
        bus.wr_en = 1'b0;
        acc = cyc;
        get_frame(f);
        check_frame("post_rst", f, 8'hA5);
        check("post_rst_latency", f.fall_cyc - acc, 2);
        repeat (3 * FRAME) @(negedge clk_50MHz);
        check("post_rst_no_extra", rx_q.size(), 0);
        check("post_rst_empty", bus.fifo_empty, 1'b1);

        // Random bytes with random gaps, never enough to fill the FIFO
        exp_q.delete();
        for (int k = 0; k < 12; k++) begin
            bus.wr_en = 1'b1;
            bus.wr_data = 8'($urandom);
            exp_q.push_back(bus.wr_data);
            @(negedge clk_50MHz);
            bus.wr_en = 1'b0;
            repeat ($urandom_range(0, FRAME + 20)) @(negedge clk_50MHz);
        end
        for (int k = 0; k < 12; k++) begin
            get_frame(f);
            check_frame($sformatf("rnd%0d", k), f, exp_q[k]);
        end
        wait_idle();
        check("rnd_overflow", bus.overflow, 1'b0);
        check("rnd_tx_idle", tx, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
